grf_mp: RTL and testbench

GRF_MP -- requirements
Module: grf_mp

---
 rtl/grf_pkg.sv | 13 +
 rtl/grf_trace_fifo.sv | 54 +++++
 rtl/grf_mp.sv | 98 +++++++++
 tb/tb_grf_mp.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared defaults and trace entry layout for the dual-write general register file.
package grf_pkg;
  localparam int DW_DEF     = 32;
  localparam int NREG_DEF   = 32;
  localparam int TDEPTH_DEF = 4;
  localparam int AW_DEF     = $clog2(NREG_DEF);

  typedef struct packed {
    logic [31:0]         pc;
    logic [AW_DEF-1:0]   addr;
    logic [DW_DEF-1:0]   data;
  } trace_entry_t;
endpackage

// File: rtl/grf_trace_fifo.sv
// Trace queue: up to two pushes and one pop per cycle, drops what does not fit, sticky overflow.
module grf_trace_fifo #(
  parameter int EW    = 69,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push0,
  input  logic          push1,
  input  logic [EW-1:0] din0,
  input  logic [EW-1:0] din1,
  input  logic          ready,
  output logic          valid,
  output logic [EW-1:0] dout,
  output logic          ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0] count_reg, free_slots;
  logic          ovf_reg, pop, adm0, adm1, drop;

  assign valid = (count_reg != '0);
  assign dout  = mem[rptr_reg];
  assign ovf   = ovf_reg;
  assign pop   = valid && ready;

  // A same-cycle pop frees a slot before admission is decided; port 0 gets first claim.
  assign free_slots = CW'(DEPTH) - count_reg + CW'(pop);
  assign adm0       = push0 && (free_slots != '0);
  assign adm1       = push1 && (free_slots > CW'(adm0));
  assign drop       = (push0 && !adm0) || (push1 && !adm1);

  always_ff @(posedge clk) begin
    if (adm0) mem[wptr_reg] <= din0;
    if (adm1) mem[wptr_reg + PW'(adm0)] <= din1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_reg + PW'(adm0) + PW'(adm1);
      rptr_reg  <= rptr_reg + PW'(pop);
      count_reg <= count_reg + CW'(adm0) + CW'(adm1) - CW'(pop);
      if (drop) ovf_reg <= 1'b1;
    end
  end
endmodule

// File: rtl/grf_mp.sv
// Two-write / two-read register file with same-cycle write bypass and a write trace queue.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int ZERO_R0 = 1,
  parameter int TDEPTH  = TDEPTH_DEF,
  localparam int AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic [31:0]   wpc0,
  input  logic [31:0]   wpc1,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [AW-1:0] trace_addr,
  output logic [DW-1:0] trace_data,
  output logic          trace_ovf
);
  localparam int EW = 32 + AW + DW;

  logic [DW-1:0] regs_q [NREG];
  logic [AW-1:0] ra_arr [2];
  logic [DW-1:0] rd_arr [2];
  logic [EW-1:0] head;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (ZERO_R0 != 0 && gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
      end else begin : g_store
        logic [DW-1:0] q_reg;
        // Port 1 is checked first so it wins an address conflict.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)                     q_reg <= '0;
          else if (we1 && wa1 == AW'(gi))   q_reg <= wd1;
          else if (we0 && wa0 == AW'(gi))   q_reg <= wd0;
        end
        assign regs_q[gi] = q_reg;
      end
    end
  endgenerate

  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_arr[gi] = '0;
        if (int'(ra_arr[gi]) >= NREG || (ZERO_R0 != 0 && ra_arr[gi] == '0))
          rd_arr[gi] = '0;
        else if (we1 && wa1 == ra_arr[gi])
          rd_arr[gi] = wd1;
        else if (we0 && wa0 == ra_arr[gi])
          rd_arr[gi] = wd0;
        else
          rd_arr[gi] = regs_q[ra_arr[gi]];
      end
    end
  endgenerate

  assign rd1 = rd_arr[0];
  assign rd2 = rd_arr[1];

  grf_trace_fifo #(
    .EW    (EW),
    .DEPTH (TDEPTH)
  ) u_trace (
    .clk     (clk),
    .reset_n (reset_n),
    .push0   (we0),
    .push1   (we1),
    .din0    ({wpc0, wa0, wd0}),
    .din1    ({wpc1, wa1, wd1}),
    .ready   (trace_ready),
    .valid   (trace_valid),
    .dout    (head),
    .ovf     (trace_ovf)
  );

  assign trace_pc   = head[EW-1 -: 32];
  assign trace_addr = head[DW +: AW];
  assign trace_data = head[DW-1:0];
endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: read vector table plus a trace scoreboard with a queue-capacity model.
module tb_grf_mp;
  import grf_pkg::*;
  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          we0 = 0, we1 = 0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic [31:0]   wpc0 = '0, wpc1 = '0;
  logic [DW-1:0] rd1, rd2;
  logic          trace_valid, trace_ready = 1'b0, trace_ovf;
  logic [31:0]   trace_pc;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;

  always #5 clk = ~clk;

  grf_mp dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .wpc0(wpc0), .wpc1(wpc1), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_ovf(trace_ovf)
  );

  int total = 0;
  int bad = 0;
  trace_entry_t exp_q[$];
  logic [DW-1:0] mdl [NREG_DEF];
  logic exp_ovf = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  typedef struct {
    logic we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
    logic we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
    logic [AW-1:0] ra1; logic [AW-1:0] ra2;
    logic [DW-1:0] e1; logic [DW-1:0] e2;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_w(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0; wpc0 = pc_ctr;
    we1 = e1; wa1 = a1; wd1 = d1; wpc1 = pc_ctr + 4;
    pc_ctr = pc_ctr + 8;
  endtask

  // Checks trace outputs against the model, advances the model, then crosses one clock edge.
  task automatic tick();
    trace_entry_t e;
    int free;
    chk("trace_valid", trace_valid, exp_q.size() != 0);
    chk("trace_ovf", trace_ovf, exp_ovf);
    if (trace_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trace_pc", trace_pc, e.pc);
      chk("trace_addr", trace_addr, e.addr);
      chk("trace_data", trace_data, e.data);
      $display("pop pc=%h addr=%0d data=%h", trace_pc, trace_addr, trace_data);
    end
    free = TDEPTH_DEF - exp_q.size();
    if (we0) begin
      if (free > 0) begin exp_q.push_back('{wpc0, wa0, wd0}); free--; end
      else exp_ovf = 1'b1;
    end
    if (we1) begin
      if (free > 0) begin exp_q.push_back('{wpc1, wa1, wd1}); free--; end
      else exp_ovf = 1'b1;
    end
    if (we0 && wa0 != 0) mdl[wa0] = wd0;
    if (we1 && wa1 != 0) mdl[wa1] = wd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_w(0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", trace_valid, 1'b0);
    chk("rst_ovf", trace_ovf, 1'b0);
    chk("rst_rd1", rd1, '0);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < NREG_DEF; i++) mdl[i] = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1, 5, 32'h11, 1, 5, 32'h22, 5, 5, 32'h22, 32'h22};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 5, 0, 32'h22, 0};
    tbl[2]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 3, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h22};
    tbl[4]  = '{1, 3, 32'hA5, 1, 9, 32'h99, 3, 9, 32'hA5, 32'h99};
    tbl[5]  = '{1, 9, 32'h100, 0, 0, 0, 9, 3, 32'h100, 32'hA5};
    tbl[6]  = '{1, 4, 32'h44, 1, 3, 32'h333, 3, 4, 32'h333, 32'h44};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 9, 4, 32'h100, 32'h44};
    tbl[8]  = '{0, 0, 0, 1, 0, 32'h77, 0, 3, 0, 32'h333};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 7, 31, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 3, 5, 32'h333, 32'h22};

    for (int i = 0; i < NREG_DEF; i++) mdl[i] = '0;
    #3;
    chk("init_valid", trace_valid, 1'b0);
    chk("init_ovf", trace_ovf, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Every address reads zero after reset.
    for (int a = 0; a < NREG_DEF; a++) begin
      ra1 = AW'(a); ra2 = AW'(NREG_DEF - 1 - a); #1;
      chk("reset_rd1", rd1, '0);
      chk("reset_rd2", rd2, '0);
    end

    // Bypass, conflict and r0 vectors; trace drains one per cycle.
    trace_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_w(tbl[i].we0, tbl[i].wa0, tbl[i].wd0, tbl[i].we1, tbl[i].wa1, tbl[i].wd1);
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      #1;
      $display("vec %0d ra1=%0d rd1=%h ra2=%0d rd2=%h", i, ra1, rd1, ra2, rd2);
      chk("vec_rd1", rd1, tbl[i].e1);
      chk("vec_rd2", rd2, tbl[i].e2);
      tick();
    end

    // Stored contents match the model.
    for (int a = 0; a < NREG_DEF; a++) begin
      ra1 = AW'(a); ra2 = AW'(a); #1;
      chk("sweep_rd1", rd1, mdl[a]);
    end

    // Fill to four with ready low, then a dual write that is entirely dropped.
    trace_ready = 1'b0;
    set_w(1, 1, 32'hA1, 1, 2, 32'hA2); tick();
    set_w(1, 3, 32'hA3, 1, 4, 32'hA4); tick();
    set_w(1, 5, 32'hA5, 1, 6, 32'hA6); tick();
    set_w(0, 0, 0, 0, 0, 0); #1;
    chk("fill_ovf", trace_ovf, 1'b1);
    trace_ready = 1'b1;
    repeat (5) tick();
    chk("drain_valid", trace_valid, 1'b0);
    chk("drain_ovf", trace_ovf, 1'b1);

    // Full queue with a pop and a dual write: port 0 kept, port 1 dropped.
    do_reset();
    trace_ready = 1'b0;
    set_w(1, 11, 32'hB1, 1, 12, 32'hB2); tick();
    set_w(1, 13, 32'hB3, 1, 14, 32'hB4); tick();
    trace_ready = 1'b1;
    set_w(1, 15, 32'hB5, 1, 16, 32'hB6); tick();
    set_w(0, 0, 0, 0, 0, 0); #1;
    chk("onefree_ovf", trace_ovf, 1'b1);
    repeat (5) tick();

    // Reset in the middle of a queued stream.
    trace_ready = 1'b0;
    set_w(1, 8, 32'hAB, 1, 7, 32'h55); tick();
    set_w(1, 10, 32'hCD, 0, 0, 0); tick();
    set_w(0, 0, 0, 0, 0, 0); ra1 = 7; #1;
    chk("pre_rst_rd7", rd1, 32'h55);
    chk("pre_rst_valid", trace_valid, 1'b1);
    do_reset();
    ra1 = 7; #1;
    chk("post_rst_rd7", rd1, '0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
